// File: rtl/pipe_mult.sv
// rtl/pipe_mult.sv - iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
module pipe_mult #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic [1:0]  op,
   input  logic [4:0]  dest_idx,
   input  logic        flush,
   output logic        done_valid,
   input  logic        done_ready,
   output logic [31:0] result,
   output logic [4:0]  done_dest_idx,
   output logic        busy
);

   localparam int N_ITER  = 32 / BITS_PER_CYCLE;
   localparam int LOG_BPC = (BITS_PER_CYCLE == 4) ? 2 : (BITS_PER_CYCLE == 2) ? 1 : 0;
   localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  iter_q;
   logic [63:0] acc_q;
   logic [31:0] mcand_q;
   logic [31:0] mplier_q;
   logic        neg_q;
   logic [1:0]  op_q;
   logic [4:0]  dest_q;
   logic [31:0] result_q;

   logic        accept;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] pp;
   logic [63:0] step_sum;
   logic [63:0] final_prod;
   logic [5:0]  shift_amt;
   logic        last_iter;

   // Handshake outputs are gated by rst so nothing looks valid while reset is held.
   assign start_ready   = (state_q == S_IDLE) && !flush && !rst;
   assign done_valid    = (state_q == S_DONE) && !rst;
   assign busy          = (state_q != S_IDLE) && !rst;
   assign accept        = start_valid && start_ready;
   assign result        = result_q;
   assign done_dest_idx = dest_q;

   // Operand conditioning: signedness from op, magnitudes of negative signed operands.
   always_comb begin
      a_neg = ((op == 2'b01) || (op == 2'b10)) && opa[31];
      b_neg = (op == 2'b01) && opb[31];
      a_mag = a_neg ? (~opa + 32'd1) : opa;
      b_mag = b_neg ? (~opb + 32'd1) : opb;
   end

   // One iteration: multiplicand times the low multiplier digit, placed at the digit weight.
   always_comb begin
      pp = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (mplier_q[j]) begin
            pp = pp + ({32'b0, mcand_q} << j);
         end
      end
      shift_amt  = {1'b0, iter_q} << LOG_BPC;
      step_sum   = acc_q + (pp << shift_amt);
      final_prod = neg_q ? (~step_sum + 64'd1) : step_sum;
      last_iter  = (iter_q == LAST_ITER);
   end

   // Next-state logic; flush wins over completion and over the result handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (flush || done_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath: capture operands on accept, accumulate in BUSY, publish result on the last iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         op_q     <= '0;
         dest_q   <= '0;
         result_q <= '0;
      end else if (accept) begin
         iter_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= a_mag;
         mplier_q <= b_mag;
         neg_q    <= a_neg ^ b_neg;
         op_q     <= op;
         dest_q   <= dest_idx;
      end else if ((state_q == S_BUSY) && !flush) begin
         mplier_q <= mplier_q >> BITS_PER_CYCLE;
         if (last_iter) begin
            acc_q    <= final_prod;
            result_q <= (op_q == 2'b00) ? final_prod[31:0] : final_prod[63:32];
            iter_q   <= '0;
         end else begin
            acc_q  <= step_sum;
            iter_q <= iter_q + 5'd1;
         end
      end else if (flush) begin
         iter_q <= '0;
      end
   end

endmodule

// File: tb/tb_pipe_mult.sv
// tb/tb_pipe_mult.sv - directed bench for pipe_mult at BITS_PER_CYCLE 1, 2 and 4
module tb_pipe_mult;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  start_valid;
   logic [31:0] opa, opb;
   logic [1:0]  op;
   logic [4:0]  dest_idx;
   logic        flush;
   logic        done_ready;

   logic [2:0]  start_ready;
   logic [2:0]  done_valid;
   logic [2:0]  busy;
   logic [31:0] result [3];
   logic [4:0]  done_dest_idx [3];

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         pipe_mult #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start_valid   (start_valid[g]),
            .start_ready   (start_ready[g]),
            .opa           (opa),
            .opb           (opb),
            .op            (op),
            .dest_idx      (dest_idx),
            .flush         (flush),
            .done_valid    (done_valid[g]),
            .done_ready    (done_ready),
            .result        (result[g]),
            .done_dest_idx (done_dest_idx[g]),
            .busy          (busy[g])
         );
      end
   endgenerate

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on instance sel with done_ready high; checks latency, result, dest, return to IDLE.
   task automatic run_op(input int sel, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d,
                         input logic [31:0] exp, input string name);
      int          n;
      int          first;
      logic [31:0] r;
      logic [4:0]  di;
      n     = 32 >> sel;
      first = -1;
      r     = '0;
      di    = '0;
      op = o; opa = a; opb = b; dest_idx = d;
      start_valid[sel] = 1'b1;
      done_ready = 1'b1;
      #1;
      check($sformatf("%s start_ready c0", name), 32'(start_ready[sel]), 32'd1);
      step();
      start_valid = '0;
      opa = $urandom; opb = $urandom; op = 2'($urandom); dest_idx = 5'($urandom);
      for (int k = 1; k <= n + 4 && first < 0; k++) begin
         if (done_valid[sel]) begin
            first = k;
            r     = result[sel];
            di    = done_dest_idx[sel];
         end else begin
            step();
         end
      end
      check($sformatf("%s latency", name), 32'(first), 32'(n + 1));
      check($sformatf("%s result", name), r, exp);
      check($sformatf("%s dest", name), 32'(di), 32'(d));
      step();
      check($sformatf("%s busy after done", name), 32'(busy[sel]), 32'd0);
      step();
      check($sformatf("%s start_ready after done", name), 32'(start_ready[sel]), 32'd1);
   endtask

   initial begin
      int first;

      vecs[0]  = '{2'b00, 32'd100,       32'd115,       32'h0000_2CEC};
      vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[6]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[8]  = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
      vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
      vecs[10] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
      vecs[12] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};

      rst = 1'b1; start_valid = '0; flush = 1'b0; done_ready = 1'b0;
      op = '0; opa = '0; opb = '0; dest_idx = '0;
      step();
      step();
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst%0d done_valid", s), 32'(done_valid[s]), 32'd0);
         check($sformatf("rst%0d busy", s), 32'(busy[s]), 32'd0);
         check($sformatf("rst%0d start_ready", s), 32'(start_ready[s]), 32'd0);
      end
      rst = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("post_rst%0d result", s), result[s], 32'd0);
         check($sformatf("post_rst%0d dest", s), 32'(done_dest_idx[s]), 32'd0);
         check($sformatf("post_rst%0d start_ready", s), 32'(start_ready[s]), 32'd1);
      end

      // Table vectors on every radix.
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 13; i++) begin
            run_op(s, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3 + s),
                   vecs[i].exp, $sformatf("vec%0d_bpc%0d", i, 1 << s));
         end
      end

      // Result held under backpressure; start_valid during DONE is ignored.
      done_ready = 1'b0;
      op = 2'b00; opa = 32'd3; opb = 32'd5; dest_idx = 5'd9;
      start_valid[0] = 1'b1;
      #1;
      step();
      start_valid = '0;
      first = -1;
      for (int k = 1; k <= 40 && first < 0; k++) begin
         if (done_valid[0]) first = k;
         else step();
      end
      check("hold latency", 32'(first), 32'd33);
      for (int h = 0; h < 5; h++) begin
         op = 2'b11; opa = $urandom; opb = $urandom; dest_idx = 5'd30;
         start_valid[0] = 1'b1;
         #1;
         check($sformatf("hold%0d result", h), result[0], 32'd15);
         check($sformatf("hold%0d dest", h), 32'(done_dest_idx[0]), 32'd9);
         check($sformatf("hold%0d start_ready", h), 32'(start_ready[0]), 32'd0);
         check($sformatf("hold%0d busy", h), 32'(busy[0]), 32'd1);
         check($sformatf("hold%0d done_valid", h), 32'(done_valid[0]), 32'd1);
         step();
      end
      start_valid = '0;
      done_ready = 1'b1;
      step();
      check("hold release busy", 32'(busy[0]), 32'd0);
      check("hold release done_valid", 32'(done_valid[0]), 32'd0);
      step();
      check("hold no stray accept", 32'(busy[0]), 32'd0);

      // Flush at iteration 10 discards the op.
      op = 2'b00; opa = 32'h0000_1234; opb = 32'h0000_5678; dest_idx = 5'd12;
      start_valid[0] = 1'b1;
      #1;
      step();
      start_valid = '0;
      repeat (10) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush busy", 32'(busy[0]), 32'd0);
      check("flush done_valid", 32'(done_valid[0]), 32'd0);
      first = 0;
      for (int k = 0; k < 40; k++) begin
         if (done_valid[0]) first++;
         step();
      end
      check("flush no late done", 32'(first), 32'd0);
      run_op(0, 2'b00, 32'd7, 32'd6, 5'd21, 32'h0000_002A, "after_flush");

      // Flush in IDLE blocks acceptance.
      flush = 1'b1;
      op = 2'b00; opa = 32'd9; opb = 32'd9; dest_idx = 5'd1;
      start_valid[0] = 1'b1;
      #1;
      check("idle flush start_ready", 32'(start_ready[0]), 32'd0);
      step();
      flush = 1'b0;
      start_valid = '0;
      check("idle flush lost start", 32'(busy[0]), 32'd0);

      // Flush together with done_ready in DONE.
      done_ready = 1'b0;
      op = 2'b00; opa = 32'd2; opb = 32'd2; dest_idx = 5'd4;
      start_valid[0] = 1'b1;
      #1;
      step();
      start_valid = '0;
      first = -1;
      for (int k = 1; k <= 40 && first < 0; k++) begin
         if (done_valid[0]) first = k;
         else step();
      end
      check("flush_done latency", 32'(first), 32'd33);
      flush = 1'b1;
      done_ready = 1'b1;
      step();
      flush = 1'b0;
      check("flush_done busy", 32'(busy[0]), 32'd0);
      check("flush_done done_valid", 32'(done_valid[0]), 32'd0);
      step();
      check("flush_done start_ready", 32'(start_ready[0]), 32'd1);

      // Reset mid-BUSY, then immediate re-issue on each radix.
      for (int s = 0; s < 3; s++) begin
         int it;
         it = (s == 0) ? 20 : ((32 >> s) - 2);
         done_ready = 1'b1;
         op = 2'b00; opa = 32'd1000; opb = 32'd1000; dest_idx = 5'd17;
         start_valid[s] = 1'b1;
         #1;
         step();
         start_valid = '0;
         repeat (it) step();
         check($sformatf("mid_rst%0d busy before", s), 32'(busy[s]), 32'd1);
         rst = 1'b1;
         #1;
         check($sformatf("mid_rst%0d done_valid in rst", s), 32'(done_valid[s]), 32'd0);
         check($sformatf("mid_rst%0d busy in rst", s), 32'(busy[s]), 32'd0);
         check($sformatf("mid_rst%0d start_ready in rst", s), 32'(start_ready[s]), 32'd0);
         step();
         rst = 1'b0;
         #1;
         check($sformatf("mid_rst%0d result", s), result[s], 32'd0);
         check($sformatf("mid_rst%0d dest", s), 32'(done_dest_idx[s]), 32'd0);
         check($sformatf("mid_rst%0d busy", s), 32'(busy[s]), 32'd0);
         check($sformatf("mid_rst%0d done_valid", s), 32'(done_valid[s]), 32'd0);
         run_op(s, 2'b00, 32'd100, 32'd115, 5'd27, 32'h0000_2CEC,
                $sformatf("reissue_bpc%0d", 1 << s));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
